// File: rtl/diff_freq_serial_in.sv
// Frequency-keyed serial receiver.
// Each bit window carries a square wave; the bit is decided by counting rising
// edges inside a fixed-length window (few edges = 0, many edges = 1). Bits are
// assembled LSB first into a DATA_BIT word that is published with a one-cycle
// valid pulse. A window with no edges at all aborts the frame with an error pulse.
module diff_freq_serial_in #(
    parameter int DATA_BIT    = 8,
    parameter int BIT_PERIOD  = 100,
    parameter int EDGE_THRESH = 4,
    parameter int CNT_BIT     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_serial_in,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_data_valid,
    output logic                o_bit_tick,
    output logic                o_bit_value,
    output logic                o_err,
    output logic                o_busy
);

    // Window counter only needs to reach BIT_PERIOD-1.
    localparam int WIN_W = $clog2(BIT_PERIOD);
    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    // One extra bit so the end-of-window total cannot overflow.
    localparam int TOT_W = CNT_BIT + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SAMPLE = 1'b1;

    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(BIT_PERIOD - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE  = WIN_W'(1);
    localparam logic [CNT_BIT-1:0] CNT_MAX  = {CNT_BIT{1'b1}};
    localparam logic [CNT_BIT-1:0] CNT_ONE  = CNT_BIT'(1);
    localparam logic [TOT_W-1:0]   THRESH   = TOT_W'(EDGE_THRESH);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BIT - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

    // Input path
    logic sync1;
    logic sync2;
    logic prev;
    logic rise;

    // Frame state
    logic [0:0]          state;
    logic [WIN_W-1:0]    win_cnt;
    logic [CNT_BIT-1:0]  edge_cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_BIT-1:0] shift;

    // Next-state values
    logic [0:0]          state_nx;
    logic [WIN_W-1:0]    win_nx;
    logic [CNT_BIT-1:0]  cnt_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic [DATA_BIT-1:0] shift_nx;
    logic [DATA_BIT-1:0] shift_upd;
    logic [DATA_BIT-1:0] data_nx;
    logic                valid_nx;
    logic                tick_nx;
    logic                bitv_nx;
    logic                err_nx;
    logic                busy_nx;

    // End-of-window decision helpers
    logic [TOT_W-1:0]    total;
    logic                win_end;
    logic                bit_dec;

    // Two-stage synchronizer for the asynchronous pin plus the previous-value stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= i_serial_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // An edge landing in the window-end cycle still belongs to the ending window.
    assign total   = {1'b0, edge_cnt} + {{CNT_BIT{1'b0}}, rise};
    assign win_end = (win_cnt == WIN_LAST);
    assign bit_dec = (total >= THRESH);

    // Frame sequencing: window counting, bit decision, word assembly
    always_comb begin
        state_nx  = state;
        win_nx    = win_cnt;
        cnt_nx    = edge_cnt;
        idx_nx    = bit_idx;
        shift_nx  = shift;
        shift_upd = shift;
        data_nx   = o_data;
        valid_nx  = 1'b0;
        tick_nx   = 1'b0;
        bitv_nx   = o_bit_value;
        err_nx    = 1'b0;

        shift_upd[bit_idx] = bit_dec;

        case (state)
            ST_IDLE: begin
                if (rise) begin
                    // The start edge is the first edge of bit 0.
                    state_nx = ST_SAMPLE;
                    win_nx   = WIN_ONE;
                    cnt_nx   = CNT_ONE;
                    idx_nx   = {IDX_W{1'b0}};
                    shift_nx = {DATA_BIT{1'b0}};
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (win_end) begin
                    if (total == {TOT_W{1'b0}}) begin
                        // Dead line: abandon the partial word, o_data untouched.
                        err_nx   = 1'b1;
                        state_nx = ST_IDLE;
                        win_nx   = {WIN_W{1'b0}};
                        cnt_nx   = {CNT_BIT{1'b0}};
                        idx_nx   = {IDX_W{1'b0}};
                        shift_nx = {DATA_BIT{1'b0}};
                    end else begin
                        tick_nx  = 1'b1;
                        bitv_nx  = bit_dec;
                        shift_nx = shift_upd;
                        win_nx   = {WIN_W{1'b0}};
                        cnt_nx   = {CNT_BIT{1'b0}};
                        if (bit_idx == IDX_LAST) begin
                            data_nx  = shift_upd;
                            valid_nx = 1'b1;
                            state_nx = ST_IDLE;
                            idx_nx   = {IDX_W{1'b0}};
                        end else begin
                            idx_nx   = bit_idx + IDX_ONE;
                            state_nx = ST_SAMPLE;
                        end
                    end
                end else begin
                    win_nx = win_cnt + WIN_ONE;
                    // Saturate rather than wrap so a noisy line still reads as 1.
                    if (rise && (edge_cnt != CNT_MAX)) begin
                        cnt_nx = edge_cnt + CNT_ONE;
                    end else begin
                        cnt_nx = edge_cnt;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                win_nx   = {WIN_W{1'b0}};
                cnt_nx   = {CNT_BIT{1'b0}};
                idx_nx   = {IDX_W{1'b0}};
                shift_nx = {DATA_BIT{1'b0}};
            end
        endcase

        busy_nx = (state_nx == ST_SAMPLE);
    end

    // Frame state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            win_cnt  <= {WIN_W{1'b0}};
            edge_cnt <= {CNT_BIT{1'b0}};
            bit_idx  <= {IDX_W{1'b0}};
            shift    <= {DATA_BIT{1'b0}};
        end else begin
            state    <= state_nx;
            win_cnt  <= win_nx;
            edge_cnt <= cnt_nx;
            bit_idx  <= idx_nx;
            shift    <= shift_nx;
        end
    end

    // Registered outputs; pulses appear the cycle after the window-end cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data       <= {DATA_BIT{1'b0}};
            o_data_valid <= 1'b0;
            o_bit_tick   <= 1'b0;
            o_bit_value  <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_data       <= data_nx;
            o_data_valid <= valid_nx;
            o_bit_tick   <= tick_nx;
            o_bit_value  <= bitv_nx;
            o_err        <= err_nx;
            o_busy       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Bench for diff_freq_serial_in. The whole pin/reset waveform is built first,
// a window-level reference model turns it into per-cycle expected outputs,
// then two DUTs (CNT_BIT=8 and CNT_BIT=4) are driven and compared every cycle.
module tb_diff_freq_serial_in;

    localparam int P    = 100;
    localparam int TH   = 4;
    localparam int NMAX = 16000;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial = 1'b0;

    logic [7:0] d8_data, d4_data;
    logic d8_valid, d8_tick, d8_bitv, d8_err, d8_busy;
    logic d4_valid, d4_tick, d4_bitv, d4_err, d4_busy;

    diff_freq_serial_in #(.DATA_BIT(8), .BIT_PERIOD(P), .EDGE_THRESH(TH), .CNT_BIT(8)) u_d8 (
        .clk(clk), .rst(rst), .i_serial_in(serial),
        .o_data(d8_data), .o_data_valid(d8_valid), .o_bit_tick(d8_tick),
        .o_bit_value(d8_bitv), .o_err(d8_err), .o_busy(d8_busy)
    );

    diff_freq_serial_in #(.DATA_BIT(8), .BIT_PERIOD(P), .EDGE_THRESH(TH), .CNT_BIT(4)) u_d4 (
        .clk(clk), .rst(rst), .i_serial_in(serial),
        .o_data(d4_data), .o_data_valid(d4_valid), .o_bit_tick(d4_tick),
        .o_bit_value(d4_bitv), .o_err(d4_err), .o_busy(d4_busy)
    );

    always #5 clk = ~clk;

    // Stimulus waveform (index = cycle in which the value is driven)
    bit pin_w [NMAX];
    bit rst_w [NMAX];
    int len = 0;

    // Expected outputs, indexed by the observation cycle
    bit         e_tick  [NMAX];
    bit         e_err   [NMAX];
    bit         e_valid [NMAX];
    bit         e_bval  [NMAX];
    bit         e_busy  [NMAX];
    logic [7:0] e_data  [NMAX];
    bit         m_tickv [NMAX];
    bit         m_set   [NMAX];
    logic [7:0] m_setv  [NMAX];
    bit         m_clr   [NMAX];
    bit         m_start [NMAX];
    bit         m_stop  [NMAX];

    int checks = 0;
    int errors = 0;
    int cp_iter = -1;
    int cp_exp  = 0;
    int ns;

    task automatic check_eq(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic put(input bit v);
        if (len < NMAX - 8) begin
            pin_w[len] = v;
            rst_w[len] = 1'b0;
            len++;
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) put(1'b0);
    endtask

    // Square wave, high first half of each period, for n cycles
    task automatic sq_part(input int period, input int n);
        for (int i = 0; i < n; i++) put((i % period) < (period / 2));
    endtask

    // One window with n single-cycle pulses; optionally the last one in the final cycle
    task automatic gen_n(input int n, input bit last_end);
        for (int i = 0; i < P; i++) begin
            bit hit = 1'b0;
            for (int j = 0; j < n; j++) begin
                int pos = (last_end && j == n - 1) ? P - 1 : (j * P) / n;
                if (pos == i) hit = 1'b1;
            end
            put(hit);
        end
    endtask

    // mode 0: 50/20-cycle square waves, 1: 4-cycle noise, 2: random pulse counts
    task automatic send_bits(input logic [7:0] d, input int nbits, input int mode);
        for (int b = 0; b < nbits; b++) begin
            case (mode)
                0: sq_part(d[b] ? 20 : 50, P);
                1: sq_part(4, P);
                default: gen_n(d[b] ? int'($urandom_range(25, 4)) : int'($urandom_range(3, 1)), 1'b0);
            endcase
        end
    endtask

    // Reference model: rising edges of the driven waveform grouped into windows
    task automatic run_model();
        bit active = 1'b0;
        int ws = 0, idx = 0, cnt = 0;
        logic [7:0] word = 8'h00;
        logic [7:0] cur_d = 8'h00;
        bit cur_b = 1'b0, cur_v = 1'b0;
        for (int k = 0; k < len; k++) begin
            bit e;
            if (rst_w[k]) begin
                active = 1'b0;
                m_clr[k+1] = 1'b1;
                m_stop[k+1] = 1'b1;
                continue;
            end
            e = (k > 0) && pin_w[k] && !pin_w[k-1];
            if (!active) begin
                if (e) begin
                    active = 1'b1; ws = k; idx = 0; cnt = 1; word = 8'h00;
                    m_start[k+LAT] = 1'b1;
                end
            end else begin
                cnt += int'(e);
                if (k == ws + P - 1) begin
                    if (cnt == 0) begin
                        e_err[k+LAT] = 1'b1;
                        m_stop[k+LAT] = 1'b1;
                        active = 1'b0;
                    end else begin
                        word[idx] = (cnt >= TH);
                        e_tick[k+LAT] = 1'b1;
                        m_tickv[k+LAT] = (cnt >= TH);
                        if (idx == 7) begin
                            e_valid[k+LAT] = 1'b1;
                            m_set[k+LAT] = 1'b1;
                            m_setv[k+LAT] = word;
                            m_stop[k+LAT] = 1'b1;
                            active = 1'b0;
                        end else begin
                            idx++; ws = k + 1; cnt = 0;
                        end
                    end
                end
            end
        end
        // Turn set/clear markers into held levels
        for (int it = 0; it < len; it++) begin
            if (m_clr[it]) begin cur_d = 8'h00; cur_v = 1'b0; end
            if (m_set[it]) cur_d = m_setv[it];
            if (e_tick[it]) cur_v = m_tickv[it];
            if (m_stop[it]) cur_b = 1'b0;
            if (m_start[it]) cur_b = 1'b1;
            e_data[it] = cur_d;
            e_busy[it] = cur_b;
            e_bval[it] = cur_v;
        end
    endtask

    initial begin
        int rc;
        // Power-on reset
        for (int i = 0; i < 4; i++) begin pin_w[len] = 1'b0; rst_w[len] = 1'b1; len++; end
        gap(10);
        // 0xA5 with nominal waveforms
        send_bits(8'hA5, 8, 0);
        gap(7);
        // Back-to-back 0x00 / 0xFF, second start edge in the first idle cycle
        send_bits(8'h00, 8, 0);
        send_bits(8'hFF, 8, 0);
        gap(9);
        // 0x3C: line goes high late in bit 3 and stays there -> error at bit 4
        send_bits(8'h3C, 4, 0);
        for (int i = 1; i <= 5; i++) pin_w[len-i] = 1'b1;
        for (int i = 0; i < 2 * P; i++) put(1'b1);
        gap(20);
        // Threshold boundary: 3-edge window, 4-edge window with the 4th in the last cycle
        for (int b = 0; b < 4; b++) begin
            gen_n(3, 1'b0);
            gen_n(4, 1'b1);
        end
        gap(12);
        // Reset in the middle of bit 5
        send_bits(8'hC3, 5, 0);
        sq_part(20, 50);
        for (int i = 1; i <= 3; i++) pin_w[len-i] = 1'b0;
        pin_w[len] = 1'b0; rst_w[len] = 1'b1; len++;
        gap(5);
        send_bits(8'h5A, 8, 0);
        gap(10);
        // Noise-rate frame; edge counter probed just before the first window end
        ns = len;
        send_bits(8'h00, 8, 1);
        cp_iter = ns + P + 1;
        cp_exp = 0;
        for (int k = ns; k <= ns + P - 2; k++)
            if (pin_w[k] && !pin_w[k-1]) cp_exp++;
        gap(6);
        // Randomised frames
        for (int f = 0; f < 6; f++) begin
            send_bits(8'($urandom), 8, int'($urandom_range(2, 0)));
            gap(int'($urandom_range(15, 0)));
        end
        gap(20);

        run_model();

        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            if (c >= 1) begin
                check_eq("d8_tick",  c, 32'(d8_tick),  32'(e_tick[c]));
                check_eq("d8_bitv",  c, 32'(d8_bitv),  32'(e_bval[c]));
                check_eq("d8_err",   c, 32'(d8_err),   32'(e_err[c]));
                check_eq("d8_valid", c, 32'(d8_valid), 32'(e_valid[c]));
                check_eq("d8_data",  c, 32'(d8_data),  32'(e_data[c]));
                check_eq("d8_busy",  c, 32'(d8_busy),  32'(e_busy[c]));
                check_eq("d4_tick",  c, 32'(d4_tick),  32'(e_tick[c]));
                check_eq("d4_bitv",  c, 32'(d4_bitv),  32'(e_bval[c]));
                check_eq("d4_err",   c, 32'(d4_err),   32'(e_err[c]));
                check_eq("d4_valid", c, 32'(d4_valid), 32'(e_valid[c]));
                check_eq("d4_data",  c, 32'(d4_data),  32'(e_data[c]));
                check_eq("d4_busy",  c, 32'(d4_busy),  32'(e_busy[c]));
            end
            if (c == cp_iter) begin
                rc = (cp_exp > 15) ? 15 : cp_exp;
                check_eq("d8_edge_cnt", c, 32'(u_d8.edge_cnt), 32'(cp_exp));
                check_eq("d4_edge_cnt_sat", c, 32'(u_d4.edge_cnt), 32'(rc));
            end
            rst = rst_w[c];
            serial = pin_w[c];
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
